// File: rtl/top.sv
// Memory-mapped math coprocessor: MULT, DIVMOD, DIVFRACT and (with MCP_SQRT_EN) SQRT over a byte-wide host bus.
// Iterative divider/root, combinational multiplier; results land within 60 clk of the opcode strobe.
module top (
  input  logic       clk,
  input  logic       reset,
  input  logic       readBus,
  input  logic       writeBus,
  input  logic [2:0] addressBus,
  inout  wire  [7:0] dataBus
);

`ifdef MCP_SQRT_EN
  localparam int RW = 20;
`else
  localparam int RW = 16;
`endif

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DIV, S_ROOT} state_t;

  state_t        state_q, state_d;
  logic          wr_prev_q, wr_prev_d;
  logic          wr_pend_q, wr_pend_d;
  logic [2:0]    wr_addr_q, wr_addr_d;
  logic [7:0]    wr_dat_q, wr_dat_d;
  logic [15:0]   a_q, a_d, b_q, b_d;
  logic [15:0]   wa_q, wa_d, wb_q, wb_d;
  logic [31:0]   x_q, x_d;
  logic          ovf_q, ovf_d, err_q, err_d;
  logic [2:0]    op_q, op_d;
  logic [RW-1:0] rem_q, rem_d;
  logic [31:0]   quo_q, quo_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [7:0]    rd_dat;

  logic [15:0] a_mag, b_mag, q_res, r_res;
  logic [31:0] prod;
  logic [16:0] rem_sh, diff;
  logic        ge;
  logic [31:0] quo_nx;
  logic [15:0] rem_nx;

  assign a_mag  = wa_q[15] ? 16'(-wa_q) : wa_q;
  assign b_mag  = wb_q[15] ? 16'(-wb_q) : wb_q;
  // Low 32 bits of the sign-extended product equal the signed product.
  assign prod   = {{16{wa_q[15]}}, wa_q} * {{16{wb_q[15]}}, wb_q};
  assign rem_sh = {rem_q[15:0], quo_q[31]};
  assign diff   = rem_sh - {1'b0, b_mag};
  assign ge     = rem_sh >= {1'b0, b_mag};
  assign quo_nx = {quo_q[30:0], ge};
  assign rem_nx = ge ? diff[15:0] : rem_sh[15:0];
  assign q_res  = (wa_q[15] ^ wb_q[15]) ? 16'(-quo_nx[15:0]) : quo_nx[15:0];
  assign r_res  = wa_q[15] ? 16'(-rem_nx) : rem_nx;

`ifdef MCP_SQRT_EN
  logic [15:0]   root_q, root_d, root_nx;
  logic [RW-1:0] sq_sh, trial;
  logic          sq_ge;
  assign sq_sh   = {rem_q[RW-3:0], quo_q[31:30]};
  assign trial   = {2'b00, root_q, 2'b01};
  assign sq_ge   = sq_sh >= trial;
  assign root_nx = {root_q[14:0], sq_ge};
`endif

  always_comb begin
    state_d   = state_q;
    wr_prev_d = writeBus;
    wr_pend_d = wr_prev_q & ~writeBus;
    wr_addr_d = wr_addr_q;
    wr_dat_d  = wr_dat_q;
    a_d = a_q;  b_d = b_q;  wa_d = wa_q;  wb_d = wb_q;
    x_d = x_q;  ovf_d = ovf_q;  err_d = err_q;  op_d = op_q;
    rem_d = rem_q;  quo_d = quo_q;  cnt_d = cnt_q;
`ifdef MCP_SQRT_EN
    root_d = root_q;
`endif
    if (wr_pend_d) begin
      wr_addr_d = addressBus;
      wr_dat_d  = dataBus;
    end

    case (state_q)
      S_EXEC: begin
        state_d = S_IDLE;
        rem_d   = '0;
        cnt_d   = '0;
        case (op_q)
          3'd0: begin
            if (wa_q == 16'h8000 || wb_q == 16'h8000) begin
              x_d = '0; ovf_d = 1'b1;
            end else x_d = prod;
          end
          3'd1, 3'd2: begin
            if (wb_q == 16'h0000) begin
              x_d = '0; err_d = 1'b1;
            end else begin
              quo_d   = (op_q == 3'd1) ? {16'h0000, a_mag} : {a_mag, 16'h0000};
              state_d = S_DIV;
            end
          end
`ifdef MCP_SQRT_EN
          3'd3: begin
            if (wa_q[15]) begin
              x_d = '0; err_d = 1'b1;
            end else begin
              quo_d   = {wa_q, 16'h0000};
              root_d  = '0;
              state_d = S_ROOT;
            end
          end
`endif
          default: begin
            x_d = '0; err_d = 1'b1;
          end
        endcase
      end
      S_DIV: begin
        rem_d = RW'(rem_nx);
        quo_d = quo_nx;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_IDLE;
          if (op_q == 3'd1) x_d = {q_res, r_res};
          else              x_d = (wa_q[15] ^ wb_q[15]) ? 32'(-quo_nx) : quo_nx;
        end
      end
`ifdef MCP_SQRT_EN
      S_ROOT: begin
        rem_d  = sq_ge ? sq_sh - trial : sq_sh;
        quo_d  = {quo_q[29:0], 2'b00};
        root_d = root_nx;
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd15) begin
          state_d = S_IDLE;
          x_d     = {8'h00, root_nx, 8'h00};
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Host writes land one cycle after the strobe; an opcode always (re)starts.
    if (wr_pend_q) begin
      case (wr_addr_q)
        3'd0: a_d[15:8] = wr_dat_q;
        3'd1: a_d[7:0]  = wr_dat_q;
        3'd2: b_d[15:8] = wr_dat_q;
        3'd3: b_d[7:0]  = wr_dat_q;
        3'd7: begin
          wa_d    = a_q;
          wb_d    = b_q;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
          op_d    = (wr_dat_q > 8'd3) ? 3'd4 : {1'b0, wr_dat_q[1:0]};
          state_d = S_EXEC;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;  wr_prev_q <= 1'b1;  wr_pend_q <= 1'b0;
      wr_addr_q <= '0;  wr_dat_q <= '0;
      a_q <= '0;  b_q <= '0;  wa_q <= '0;  wb_q <= '0;
      x_q <= '0;  ovf_q <= 1'b0;  err_q <= 1'b0;  op_q <= '0;
      rem_q <= '0;  quo_q <= '0;  cnt_q <= '0;
`ifdef MCP_SQRT_EN
      root_q <= '0;
`endif
    end else begin
      state_q <= state_d;  wr_prev_q <= wr_prev_d;  wr_pend_q <= wr_pend_d;
      wr_addr_q <= wr_addr_d;  wr_dat_q <= wr_dat_d;
      a_q <= a_d;  b_q <= b_d;  wa_q <= wa_d;  wb_q <= wb_d;
      x_q <= x_d;  ovf_q <= ovf_d;  err_q <= err_d;  op_q <= op_d;
      rem_q <= rem_d;  quo_q <= quo_d;  cnt_q <= cnt_d;
`ifdef MCP_SQRT_EN
      root_q <= root_d;
`endif
    end
  end

  always_comb begin
    rd_dat = 8'h00;
    case (addressBus)
      3'd0: rd_dat = x_q[31:24];
      3'd1: rd_dat = x_q[23:16];
      3'd2: rd_dat = x_q[15:8];
      3'd3: rd_dat = x_q[7:0];
      3'd4: rd_dat = {5'b00000, err_q, ovf_q, state_q != S_IDLE};
      default: rd_dat = 8'h00;
    endcase
  end

  assign dataBus = readBus ? 8'bzzzz_zzzz : rd_dat;

endmodule

// File: tb/tb_top.sv
// Randomized self-checking bench for top against a plain-arithmetic reference model.
module tb_top;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       readBus = 1'b1;
  logic       writeBus = 1'b1;
  logic [2:0] addressBus = 3'd0;
  logic [7:0] drv_dat = 8'h00;
  logic       drv_en = 1'b0;
  wire  [7:0] dataBus;

  int errors = 0;
  int checks = 0;
  logic [31:0] last_x = 32'h0;

  assign dataBus = drv_en ? drv_dat : 8'bzzzz_zzzz;

  top dut (
    .clk(clk), .reset(reset), .readBus(readBus), .writeBus(writeBus),
    .addressBus(addressBus), .dataBus(dataBus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [2:0] ad, input logic [7:0] d);
    @(negedge clk);
    addressBus = ad; drv_dat = d; drv_en = 1'b1; writeBus = 1'b0;
    @(negedge clk);
    writeBus = 1'b1;
    @(negedge clk);
    drv_en = 1'b0;
  endtask

  task automatic rd(input logic [2:0] ad, output logic [7:0] v);
    addressBus = ad; readBus = 1'b0;
    #1 v = dataBus;
    readBus = 1'b1;
  endtask

  task automatic read_x(output logic [31:0] x);
    logic [7:0] b0, b1, b2, b3;
    rd(3'd0, b0); rd(3'd1, b1); rd(3'd2, b2); rd(3'd3, b3);
    x = {b0, b1, b2, b3};
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  // Reference: results straight from the arithmetic definitions of each op.
  task automatic model(input logic [15:0] a, input logic [15:0] b, input logic [7:0] op,
                       output logic [31:0] x, output logic [7:0] st);
    int sa, sb, q, r;
    longint n, d, lq;
    sa = int'($signed(a)); sb = int'($signed(b));
    x = 32'h0; st = 8'h00;
    if (op == 8'd0) begin
      if (a == 16'h8000 || b == 16'h8000) st = 8'h02;
      else x = sa * sb;
    end else if (op == 8'd1 || op == 8'd2) begin
      if (sb == 0) st = 8'h04;
      else if (op == 8'd1) begin
        q = sa / sb; r = sa % sb;
        x = {q[15:0], r[15:0]};
      end else begin
        n = (sa < 0 ? -sa : sa); n = n * 65536;
        d = (sb < 0 ? -sb : sb);
        lq = n / d;
        if ((sa < 0) != (sb < 0)) lq = -lq;
        x = lq[31:0];
      end
    end else if (op == 8'd3) begin
`ifdef MCP_SQRT_EN
      if (sa < 0) st = 8'h04;
      else begin
        int rt;
        n = longint'(sa) * 65536;
        rt = 0;
        for (int k = 15; k >= 0; k--) begin
          int t;
          t = rt | (1 << k);
          if (longint'(t) * t <= n) rt = t;
        end
        x = {8'h00, rt[15:0], 8'h00};
      end
`else
      st = 8'h04;
`endif
    end else st = 8'h04;
  endtask

  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic [7:0] op);
    wr(3'd0, a[15:8]); wr(3'd1, a[7:0]); wr(3'd2, b[15:8]); wr(3'd3, b[7:0]);
    wr(3'd7, op);
  endtask

  task automatic wait_done(input string tag);
    logic [7:0] s;
    int n;
    n = 2;
    rd(3'd4, s);
    while (s[0] && n < 70) begin
      @(negedge clk); n++;
      rd(3'd4, s);
    end
    check({tag, ":latency_ok"}, 32'(n <= 58), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [7:0] op, input logic [31:0] ex, input logic [7:0] est);
    logic [31:0] x;
    logic [7:0]  s;
    start_op(a, b, op);
    rd(3'd4, s);
    check({tag, ":busy"}, 32'(s), 32'h1);
    read_x(x);
    check({tag, ":hold"}, x, last_x);
    wait_done(tag);
    read_x(x);
    check({tag, ":x"}, x, ex);
    rd(3'd4, s);
    check({tag, ":st"}, 32'(s), 32'(est));
    last_x = ex;
  endtask

  task automatic run_model(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [7:0] op);
    logic [31:0] ex;
    logic [7:0]  est;
    model(a, b, op, ex, est);
    run_op(tag, a, b, op, ex, est);
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0: return 16'h8000;
      1: return 16'h0000;
      2: return 16'h7FFF;
      3: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  typedef struct { logic [7:0] op; logic [15:0] a, b; logic [31:0] x; logic [7:0] st; } vec_t;

  initial begin
    vec_t vecs[$];
    logic [31:0] x;
    logic [7:0]  s;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    read_x(x);
    check("reset:x", x, 32'h0);
    rd(3'd4, s);
    check("reset:st", 32'(s), 32'h0);
    rd(3'd6, s);
    check("reset:addr6", 32'(s), 32'h0);

    vecs = '{
      '{8'd0, 16'h7FFF, 16'h7FFF, 32'h3FFF0001, 8'h0},
      '{8'd0, 16'h8001, 16'h8001, 32'h3FFF0001, 8'h0},
      '{8'd0, 16'h8000, 16'h8000, 32'h00000000, 8'h2},
      '{8'd0, 16'hFFF0, 16'hFFFF, 32'h00000010, 8'h0},
      '{8'd0, 16'h0001, 16'hFFFF, 32'hFFFFFFFF, 8'h0},
      '{8'd1, 16'h0003, 16'h0002, 32'h00010001, 8'h0},
      '{8'd1, 16'h7FFE, 16'h7FFF, 32'h00007FFE, 8'h0},
      '{8'd1, 16'hFFF0, 16'h0003, 32'hFFFBFFFF, 8'h0},
      '{8'd1, 16'hFD00, 16'hFF00, 32'h00030000, 8'h0},
      '{8'd1, 16'h0005, 16'h0000, 32'h00000000, 8'h4},
      '{8'd2, 16'h0003, 16'h0002, 32'h00018000, 8'h0},
      '{8'd2, 16'h7FFF, 16'h0003, 32'h2AAA5555, 8'h0},
      '{8'd2, 16'h000A, 16'h0003, 32'h00035555, 8'h0},
      '{8'd2, 16'h0001, 16'h0004, 32'h00004000, 8'h0},
      '{8'd5, 16'h0001, 16'h0001, 32'h00000000, 8'h4},
      '{8'd0, 16'hAAAA, 16'h0001, 32'hFFFFAAAA, 8'h0}
    };
`ifdef MCP_SQRT_EN
    vecs.push_back('{8'd3, 16'h0004, 16'h0000, 32'h00020000, 8'h0});
    vecs.push_back('{8'd3, 16'h0064, 16'h0000, 32'h000A0000, 8'h0});
    vecs.push_back('{8'd3, 16'h0002, 16'h1234, 32'h00016A00, 8'h0});
    vecs.push_back('{8'd3, 16'h7FFF, 16'h0000, 32'h00B50400, 8'h0});
    vecs.push_back('{8'd3, 16'hFFFF, 16'h0000, 32'h00000000, 8'h4});
`else
    vecs.push_back('{8'd3, 16'h0004, 16'h0000, 32'h00000000, 8'h4});
`endif
    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].x, vecs[i].st);

    // Opcode rewrite mid-divide restarts with the new operation.
    start_op(16'h7FFF, 16'h0003, 8'd2);
    repeat (5) @(negedge clk);
    wr(3'd7, 8'd0);
    wait_done("abort");
    read_x(x);
    check("abort:x", x, 32'h00017FFD);
    last_x = 32'h00017FFD;

    // Reset in the middle of a DIVFRACT clears everything.
    start_op(16'h7FFF, 16'h0003, 8'd2);
    repeat (6) @(negedge clk);
    do_reset();
    read_x(x);
    check("midrst:x", x, 32'h0);
    rd(3'd4, s);
    check("midrst:st", 32'(s), 32'h0);
    last_x = 32'h0;
    run_op("postrst", 16'h0003, 16'h0002, 8'd2, 32'h00018000, 8'h0);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] op;
      op = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, 3));
      run_model($sformatf("rnd%0d", i), pick(), pick(), op);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
